// File: rtl/dec_bundle_seq_pkg.sv
// Core definitions shared by the bundle sequencer and the decoder:
// op-size majors, continuation bit, FE jumbo prefix, sequencer states.
package dec_bundle_seq_pkg;

  localparam logic [3:0]  OP32_MAJ_E  = 4'b1110;
  localparam logic [3:0]  OP32_MAJ_F  = 4'b1111;
  localparam int unsigned CONT_BIT    = 10;
  localparam logic [7:0]  JUMBO_PFX   = 8'hFE;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_ALIGN,
    ST_RUN
  } seq_state_e;

  // A lead halfword with major E or F opens a 32-bit op.
  function automatic logic is_op32(input logic [15:0] h);
    return (h[15:12] == OP32_MAJ_E) || (h[15:12] == OP32_MAJ_F);
  endfunction

  // A 32-bit op chains to the next op when its continuation bit is set and
  // either WEX is enabled or the op carries the FE jumbo prefix.
  function automatic logic op_continues(input logic [15:0] h, input logic wxe);
    return is_op32(h) && h[CONT_BIT] && (wxe || (h[15:8] == JUMBO_PFX));
  endfunction

endpackage

// File: rtl/dec_bundle_seq_if.sv
// Fetch and decode handshakes of the bundle sequencer.
interface dec_bundle_seq_if;
  logic [63:0] fetchData;
  logic        fetchValid;
  logic        fetchReady;
  logic [95:0] decWord;
  logic [31:0] decPc;
  logic [2:0]  decLenHw;
  logic        decValid;
  logic        decReady;

  // Environment side: supplies fetch beats, consumes bundles.
  modport master (
    output fetchData, fetchValid, decReady,
    input  fetchReady, decWord, decPc, decLenHw, decValid
  );

  // Sequencer side.
  modport slave (
    input  fetchData, fetchValid, decReady,
    output fetchReady, decWord, decPc, decLenHw, decValid
  );
endinterface

// File: rtl/dec_bundle_seq_len.sv
// Combinational bundle sizing from the lead halfwords of up to three ops.
module dec_bundle_len
  import dec_bundle_seq_pkg::*;
#(
  parameter int unsigned OCC_W = 4
) (
  input  logic [15:0]      i_h0,
  input  logic [15:0]      i_h2,
  input  logic [15:0]      i_h4,
  input  logic             i_wxe,
  input  logic [OCC_W-1:0] i_occ,
  output logic [2:0]       o_len,
  output logic             o_sufficient
);

  // The third op always closes the chain, so its lead never affects length.
  logic w_unused_h4;
  assign w_unused_h4 = ^i_h4;

  // Length 1/2/4/6; h2 is only consulted once h0 is known to continue.
  always_comb begin
    if (!is_op32(i_h0))                o_len = 3'd1;
    else if (!op_continues(i_h0, i_wxe)) o_len = 3'd2;
    else if (!op_continues(i_h2, i_wxe)) o_len = 3'd4;
    else                                 o_len = 3'd6;
  end

  // Stale halfwords beyond occ can only yield a length that already exceeds
  // occ, so comparing against the computed length is always safe.
  assign o_sufficient = (i_occ >= OCC_W'(o_len));

endmodule

// File: rtl/dec_bundle_seq.sv
// Halfword queue between fetch and a 3-wide decoder: aligns on redirect,
// sizes WEX/jumbo bundles and retires one bundle per cycle.
module dec_bundle_seq
  import dec_bundle_seq_pkg::*;
#(
  parameter int unsigned BUF_HW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            srWxe,
  input  logic            redirValid,
  input  logic [31:0]     redirPc,
  dec_bundle_seq_if.slave bus
);

  localparam int unsigned      OCC_W       = $clog2(BUF_HW + 1);
  localparam int unsigned      PTR_W       = $clog2(BUF_HW);
  localparam logic [OCC_W-1:0] FETCH_LIMIT = OCC_W'(BUF_HW - 4);

  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base,
                                              input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= BUF_HW) sum = sum - BUF_HW;
    return sum[PTR_W-1:0];
  endfunction

  seq_state_e       r_state, w_state_nxt;
  logic [15:0]      r_buf [BUF_HW];
  logic [PTR_W-1:0] r_head, w_tail;
  logic [OCC_W-1:0] r_occ, w_occ_nxt;
  logic [1:0]       r_skip, w_drop;
  logic [31:0]      r_pc;
  logic             r_parked, r_hold, r_wxe_q, w_wxe;
  logic [15:0]      w_hw [6];
  logic [2:0]       w_len;
  logic             w_suff, w_dec_valid, w_retire, w_fetch_ready, w_accept;
  logic [95:0]      w_word;
  logic             w_unused_pc0;

  assign w_unused_pc0 = redirPc[0];

  // Candidate bundle halfwords starting at the head.
  always_comb begin
    for (int unsigned k = 0; k < 6; k++) w_hw[k] = r_buf[f_wrap(r_head, k)];
  end

  assign w_tail = f_wrap(r_head, 32'(r_occ));
  // While a bundle is held, sizing keeps the WEX value it was presented with.
  assign w_wxe  = r_hold ? r_wxe_q : srWxe;

  dec_bundle_len #(.OCC_W(OCC_W)) u_len (
    .i_h0         (w_hw[0]),
    .i_h2         (w_hw[2]),
    .i_h4         (w_hw[4]),
    .i_wxe        (w_wxe),
    .i_occ        (r_occ),
    .o_len        (w_len),
    .o_sufficient (w_suff)
  );

  assign w_dec_valid   = (r_state == ST_RUN) && w_suff;
  assign w_retire      = w_dec_valid && bus.decReady && !redirValid;
  assign w_fetch_ready = (r_state != ST_FLUSH) && !redirValid && (r_occ <= FETCH_LIMIT);
  assign w_accept      = bus.fetchValid && w_fetch_ready;
  assign w_drop        = (r_state == ST_ALIGN) ? r_skip : 2'd0;

  // Net occupancy after a same-cycle retire and accept.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_retire) w_occ_nxt = w_occ_nxt - OCC_W'(w_len);
    if (w_accept) w_occ_nxt = w_occ_nxt + OCC_W'(3'd4 - 3'(w_drop));
  end

  // Present the bundle with halfwords beyond its length zeroed.
  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (k < 32'(w_len)) w_word[16*k +: 16] = w_hw[k];
    end
  end

  // Next state: redirect wins; after reset FLUSH is parked until a redirect.
  always_comb begin
    w_state_nxt = r_state;
    if (redirValid) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      unique case (r_state)
        ST_FLUSH: if (!r_parked) w_state_nxt = ST_ALIGN;
        ST_ALIGN: if (w_accept)  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_FLUSH;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_FLUSH;
    else        r_state <= w_state_nxt;
  end

  // Queue, pointers, bundle PC and redirect bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head   <= '0;
      r_occ    <= '0;
      r_skip   <= '0;
      r_pc     <= '0;
      r_parked <= 1'b1;
      r_hold   <= 1'b0;
      r_wxe_q  <= 1'b0;
      for (int unsigned i = 0; i < BUF_HW; i++) r_buf[i] <= '0;
    end else if (redirValid) begin
      r_occ    <= '0;
      r_pc     <= {redirPc[31:1], 1'b0};
      r_skip   <= redirPc[2:1];
      r_parked <= 1'b0;
      r_hold   <= 1'b0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_hold  <= w_dec_valid && !bus.decReady;
      r_wxe_q <= w_wxe;
      if (w_retire) begin
        r_head <= f_wrap(r_head, 32'(w_len));
        r_pc   <= r_pc + 32'({w_len, 1'b0});
      end
      if (w_accept) begin
        for (int unsigned j = 0; j < 4; j++) begin
          if (j >= 32'(w_drop))
            r_buf[f_wrap(w_tail, j - 32'(w_drop))] <= bus.fetchData[16*j +: 16];
        end
      end
    end
  end

  assign bus.fetchReady = w_fetch_ready;
  assign bus.decValid   = w_dec_valid;
  assign bus.decWord    = w_word;
  assign bus.decPc      = r_pc;
  assign bus.decLenHw   = w_len;

endmodule

// File: doc/dec_bundle_seq.md
DEC_BUNDLE_SEQ -- requirements
Module: dec_bundle_seq

Interface
REQ-001 Parameter BUF_HW, default 8: buffer depth in 16-bit halfwords; legal values are 8 or 12.
REQ-002 clock  in  1  core clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 srWxe  in  1  WEX enable (SR.WXE), sampled when a bundle is sized.
REQ-005 redirValid  in  1  branch/redirect request.
REQ-006 redirPc  in  32  redirect target address (bit 0 ignored).
REQ-007 fetchData  in  64  fetched block, 8-byte aligned, little-endian halfwords.
REQ-008 fetchValid / fetchReady  in / out  1 / 1  fetch handshake; a beat transfers when both are high.
REQ-009 decWord  out  96  bundle to the 3-wide decoder; lowest op in [31:0]; bits above the bundle length are zero.
REQ-010 decPc  out  32  address of the bundle's first halfword.
REQ-011 decLenHw  out  3  bundle length in halfwords: 1, 2, 4 or 6.
REQ-012 decValid / decReady  out / in  1 / 1  decode handshake; a bundle retires when both are high.

Function
REQ-013 Internal storage: BUF_HW-halfword queue; occupancy counter occ (0..BUF_HW); head pointer wraps modulo BUF_HW.
REQ-014 Op sizing: halfword h[15:12] in {1110, 1111} gives a 32-bit op; otherwise a 16-bit op.
REQ-015 Continuation: a 32-bit op continues the bundle when h[10]=1 and (srWxe=1 or h[15:8]=8'hFE).
REQ-016 Bundle length is 1 halfword for a 16-bit op.
REQ-017 Bundle length is 2 for a non-continuing 32-bit op, 4 when the first op continues, and 6 when the second op also continues.
REQ-018 The chain is capped at 6 halfwords; the third op's continuation bit is ignored.
REQ-019 decValid=1 iff the state is RUN and occ ≥ the required length; the first halfword alone suffices to size a 16-bit op.
REQ-020 If sizing needs halfwords not yet present, decValid=0 until they arrive; decWord is not required to be stable while decValid=0.
REQ-021 Retire: occ -= decLenHw, head advances by decLenHw, and decPc += 2*decLenHw (mod 2^32).
REQ-022 fetchReady=1 iff the state is not FLUSH and occ ≤ BUF_HW-4.
REQ-023 Accept: 4 halfwords are appended; occ += 4, minus any halfwords dropped under REQ-026.
REQ-024 A retire and an accept in the same cycle both apply; the net occ is updated in one step.
REQ-025 While decValid=1 and decReady=0, decWord, decPc and decLenHw are held stable.
REQ-026 States: FLUSH, ALIGN, RUN.
 - FLUSH: entered for one cycle on redirValid; occ is cleared, decPc is set to {redirPc[31:1],0}, and skip is set to redirPc[2:1]. FLUSH -> ALIGN.
 - ALIGN: the first accepted beat drops its lowest skip halfwords (occ += 4-skip). ALIGN -> RUN on that accept.
 - RUN: normal operation.
REQ-027 redirValid has priority in any state: it overrides a same-cycle retire or accept, and neither is counted.
REQ-028 A fetch beat presented in the redirect cycle is not accepted (fetchReady=0 in that cycle).
REQ-029 srWxe is combinational into sizing; a change while a bundle is held may alter decLenHw only if decValid=0.
REQ-030 Throughput: one bundle per cycle when occ is sufficient; no bubble between back-to-back bundles.

Reset
REQ-031 On reset low, asynchronously: state=FLUSH, occ=0, head=0, skip=0, decPc=0, decValid=0, fetchReady=0, decWord=0, decLenHw=1.
REQ-032 After reset deasserts, the block stays in FLUSH until the first redirValid.
REQ-033 A reset asserted mid-bundle discards all buffered halfwords.

Structure
REQ-034 The op-size, continuation and FE-jumbo prefix constants belong in CoreDefs, shared with the decoder.
REQ-035 Bundle sizing is one combinational sub-module, dec_bundle_len: inputs are the three candidate lead halfwords, srWxe and occ; outputs are the length and a sufficient flag.
REQ-036 The queue, pointers and FSM live in dec_bundle_seq.

Verification
REQ-037 Redirect to 0x1002, then fetch 64'h0004_0003_0002_0001 with decReady=1 -> three bundles: decPc=0x1002/1004/1006, decLenHw=1, and decWord[15:0]=0002, 0003, then 0004 once the 16-bit op is visible.
REQ-038 srWxe=1, fetch halfwords F400,1234,F000,5678 at pc 0 -> one bundle with decLenHw=4 and decWord[63:0]=5678_F000_1234_F400; with srWxe=0 -> two bundles of decLenHw=2.
REQ-039 srWxe=0, fetch FE00,AAAA,FE00,BBBB,F000,CCCC -> decLenHw=6 despite srWxe=0.
REQ-040 Hold decReady=0 for 5 cycles with occ=8 -> fetchReady=0, outputs stable; release -> occ drains with no lost or duplicated halfword.
REQ-041 Assert redirValid in the same cycle as a retire and an accept -> occ=0, decPc=new target, the next decValid only after a fresh beat.
REQ-042 Assert reset while decValid=1 -> decValid=0 immediately (asynchronously); no output until a redirect is issued.
